// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO input filter: register map, field split
// widths and the register-window decoder.
package gpio_pkg;

  localparam int unsigned GPIO_FILT_PERIOD  = 32'h0000_1200;
  localparam int unsigned GPIO_FILT_STAT_LO = 32'h0000_1204;
  localparam int unsigned GPIO_FILT_STAT_HI = 32'h0000_1208;
  localparam int unsigned GPIO_FILT_IEN_LO  = 32'h0000_120C;
  localparam int unsigned GPIO_FILT_IEN_HI  = 32'h0000_1210;
  localparam int unsigned GPIO_FILT_LVL_LO  = 32'h0000_1214;
  localparam int unsigned GPIO_FILT_LVL_HI  = 32'h0000_1218;

  localparam int GPIO_LO_W = 24;
  localparam int GPIO_HI_W = 10;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_PERIOD,
    REG_STAT_LO,
    REG_STAT_HI,
    REG_IEN_LO,
    REG_IEN_HI,
    REG_LVL_LO,
    REG_LVL_HI
  } gpio_reg_e;

  function automatic gpio_reg_e decodeReg(input logic [31:0] byteAddr);
    case (byteAddr)
      GPIO_FILT_PERIOD:  return REG_PERIOD;
      GPIO_FILT_STAT_LO: return REG_STAT_LO;
      GPIO_FILT_STAT_HI: return REG_STAT_HI;
      GPIO_FILT_IEN_LO:  return REG_IEN_LO;
      GPIO_FILT_IEN_HI:  return REG_IEN_HI;
      GPIO_FILT_LVL_LO:  return REG_LVL_LO;
      GPIO_FILT_LVL_HI:  return REG_LVL_HI;
      default:           return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/gpio_in_filter_debounce_bit.sv
// One GPIO bit: two-flop synchroniser, saturating debounce counter and the
// filtered level, plus a single-cycle pulse on the edge the level changes.
module gpio_debounce_bit #(
  parameter int FilterWidth = 8
) (
  input  logic                   CLOCK,
  input  logic                   reset_reg,
  input  logic                   i_raw,
  input  logic [FilterWidth-1:0] i_period,
  output logic                   o_filt,
  output logic                   o_edge
);

  logic                   r_s1;
  logic                   r_s2;
  logic                   r_filt;
  logic [FilterWidth-1:0] r_cnt;
  logic                   w_commit;

  // >= rather than == so that lowering the period mid-count commits at once
  assign w_commit = (r_s2 != r_filt) && (r_cnt >= i_period);

  always_ff @(posedge CLOCK or posedge reset_reg) begin
    if (reset_reg) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 == r_filt) begin
        r_cnt <= '0;
      end else if (w_commit) begin
        r_filt <= r_s2;
        r_cnt  <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_filt = r_filt;
  assign o_edge = w_commit;

endmodule

// File: rtl/gpio_in_filter.sv
// GPIO input conditioning: per-bit debounce, any-edge W1C status, interrupt
// enables and a level interrupt, all behind a small host register window.
module gpio_in_filter
  import gpio_pkg::*;
#(
  parameter int AddrWidth      = 14,
  parameter int BusWidth       = 32,
  parameter int MuxGPIOIOWidth = 34,
  parameter int FilterWidth    = 8,
  parameter int DefaultFilter  = 4
) (
  input  logic                      CLOCK,
  input  logic                      reset_reg,
  input  logic                      write_reg,
  input  logic                      read_reg,
  input  logic [AddrWidth-3:0]      busaddress,
  input  logic [BusWidth-1:0]       busdata_in,
  input  logic [MuxGPIOIOWidth-1:0] iodatafromgpio,
  output logic [MuxGPIOIOWidth-1:0] iofiltered,
  output logic [BusWidth-1:0]       busdata_out,
  output logic                      busdata_valid,
  output logic                      irq
);

  logic                      r_wrStage0;
  logic                      r_wrStage1;
  logic                      r_rdStage0;
  logic                      r_rdStage1;
  logic [AddrWidth-3:0]      r_addr;
  logic [BusWidth-1:0]       r_data;
  logic [FilterWidth-1:0]    r_period;
  logic [MuxGPIOIOWidth-1:0] r_stat;
  logic [MuxGPIOIOWidth-1:0] r_ien;
  logic [BusWidth-1:0]       r_busData;
  logic                      r_busValid;
  logic                      r_irq;

  logic [MuxGPIOIOWidth-1:0] w_filt;
  logic [MuxGPIOIOWidth-1:0] w_edge;
  logic [MuxGPIOIOWidth-1:0] w_clr;
  logic [BusWidth-1:0]       w_rdData;
  logic                      w_wrCommit;
  logic                      w_rdCommit;
  gpio_reg_e                 w_reg;
  logic                      w_unused;

  for (genvar g = 0; g < MuxGPIOIOWidth; g++) begin : g_bit
    gpio_debounce_bit #(
      .FilterWidth(FilterWidth)
    ) u_bit (
      .CLOCK    (CLOCK),
      .reset_reg(reset_reg),
      .i_raw    (iodatafromgpio[g]),
      .i_period (r_period),
      .o_filt   (w_filt[g]),
      .o_edge   (w_edge[g])
    );
  end

  // A strobe may be held for many cycles; only its first cycle acts
  assign w_wrCommit = r_wrStage0 & ~r_wrStage1;
  assign w_rdCommit = r_rdStage0 & ~r_rdStage1;
  assign w_reg      = decodeReg(32'({r_addr, 2'b00}));
  assign w_unused   = &{1'b0, r_data[BusWidth-1:GPIO_LO_W]};

  always_ff @(posedge CLOCK or posedge reset_reg) begin
    if (reset_reg) begin
      r_wrStage0 <= 1'b0;
      r_wrStage1 <= 1'b0;
      r_rdStage0 <= 1'b0;
      r_rdStage1 <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_wrStage0 <= write_reg;
      r_wrStage1 <= r_wrStage0;
      r_rdStage0 <= read_reg;
      r_rdStage1 <= r_rdStage0;
      r_addr     <= busaddress;
      r_data     <= busdata_in;
    end
  end

  always_comb begin
    w_clr = '0;
    if (w_wrCommit && (w_reg == REG_STAT_LO))
      w_clr[GPIO_LO_W-1:0] = r_data[GPIO_LO_W-1:0];
    if (w_wrCommit && (w_reg == REG_STAT_HI))
      w_clr[GPIO_LO_W +: GPIO_HI_W] = r_data[GPIO_HI_W-1:0];
  end

  always_comb begin
    w_rdData = '0;
    case (w_reg)
      REG_PERIOD:  w_rdData[FilterWidth-1:0] = r_period;
      REG_STAT_LO: w_rdData[GPIO_LO_W-1:0]   = r_stat[GPIO_LO_W-1:0];
      REG_STAT_HI: w_rdData[GPIO_HI_W-1:0]   = r_stat[GPIO_LO_W +: GPIO_HI_W];
      REG_IEN_LO:  w_rdData[GPIO_LO_W-1:0]   = r_ien[GPIO_LO_W-1:0];
      REG_IEN_HI:  w_rdData[GPIO_HI_W-1:0]   = r_ien[GPIO_LO_W +: GPIO_HI_W];
      REG_LVL_LO:  w_rdData[GPIO_LO_W-1:0]   = w_filt[GPIO_LO_W-1:0];
      REG_LVL_HI:  w_rdData[GPIO_HI_W-1:0]   = w_filt[GPIO_LO_W +: GPIO_HI_W];
      default:     w_rdData = '0;
    endcase
  end

  // New edges are OR-ed in after the clear so a simultaneous set survives
  always_ff @(posedge CLOCK or posedge reset_reg) begin
    if (reset_reg) begin
      r_period <= FilterWidth'(DefaultFilter);
      r_ien    <= '0;
      r_stat   <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_stat <= (r_stat & ~w_clr) | w_edge;
      r_irq  <= |(r_stat & r_ien);
      if (w_wrCommit) begin
        case (w_reg)
          REG_PERIOD: r_period <= r_data[FilterWidth-1:0];
          REG_IEN_LO: r_ien[GPIO_LO_W-1:0] <= r_data[GPIO_LO_W-1:0];
          REG_IEN_HI: r_ien[GPIO_LO_W +: GPIO_HI_W] <= r_data[GPIO_HI_W-1:0];
          default:    ;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK or posedge reset_reg) begin
    if (reset_reg) begin
      r_busData  <= '0;
      r_busValid <= 1'b0;
    end else begin
      r_busValid <= w_rdCommit;
      if (w_rdCommit)
        r_busData <= w_rdData;
    end
  end

  assign iofiltered    = w_filt;
  assign busdata_out   = r_busData;
  assign busdata_valid = r_busValid;
  assign irq           = r_irq;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Bench for gpio_in_filter: directed register/timing checks plus a random
// phase compared every cycle against a behavioural model of the block.
module tb_gpio_in_filter;

  localparam int AW = 14;
  localparam int BW = 32;
  localparam int NB = 34;
  localparam int FW = 8;

  logic          CLOCK = 1'b0;
  logic          reset_reg = 1'b1;
  logic          write_reg = 1'b0;
  logic          read_reg = 1'b0;
  logic [AW-3:0] busaddress = '0;
  logic [BW-1:0] busdata_in = '0;
  logic [NB-1:0] iodatafromgpio = '0;
  logic [NB-1:0] iofiltered;
  logic [BW-1:0] busdata_out;
  logic          busdata_valid;
  logic          irq;

  int total = 0;
  int bad = 0;
  bit checkEn = 1'b0;

  gpio_in_filter #(
    .AddrWidth(AW), .BusWidth(BW), .MuxGPIOIOWidth(NB),
    .FilterWidth(FW), .DefaultFilter(4)
  ) dut (
    .CLOCK(CLOCK), .reset_reg(reset_reg), .write_reg(write_reg),
    .read_reg(read_reg), .busaddress(busaddress), .busdata_in(busdata_in),
    .iodatafromgpio(iodatafromgpio), .iofiltered(iofiltered),
    .busdata_out(busdata_out), .busdata_valid(busdata_valid), .irq(irq)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: a pin level is accepted once the synchronised value
  // has disagreed with the accepted level for PERIOD consecutive edges.
  logic [NB-1:0] mRawD1, mRawD2, mF, mStat, mIen, mS2, mCommit, mClr;
  logic [FW-1:0] mPeriod;
  logic          mIrq, mValid, mWrPrev, mRdPrev, mWrPend, mRdPend;
  logic [BW-1:0] mBusData, mWrData;
  logic [AW-3:0] mWrAddr, mRdAddr;
  int            mSince [NB];
  int            edgeCount;

  function automatic logic [31:0] modelRead(input logic [AW-3:0] wa);
    logic [31:0] v;
    v = '0;
    case ({wa, 2'b00})
      14'h1200: v = {24'h0, mPeriod};
      14'h1204: v = {8'h0, mStat[23:0]};
      14'h1208: v = {22'h0, mStat[33:24]};
      14'h120C: v = {8'h0, mIen[23:0]};
      14'h1210: v = {22'h0, mIen[33:24]};
      14'h1214: v = {8'h0, mF[23:0]};
      14'h1218: v = {22'h0, mF[33:24]};
      default:  v = '0;
    endcase
    return v;
  endfunction

  always @(posedge CLOCK or posedge reset_reg) begin
    if (reset_reg) begin
      mRawD1 = '0; mRawD2 = '0; mF = '0; mStat = '0; mIen = '0;
      mPeriod = 8'd4; mIrq = 1'b0; mValid = 1'b0; mBusData = '0;
      mWrPrev = 1'b0; mRdPrev = 1'b0; mWrPend = 1'b0; mRdPend = 1'b0;
      mWrAddr = '0; mRdAddr = '0; mWrData = '0; edgeCount = 0;
      for (int b = 0; b < NB; b++) mSince[b] = -1;
    end else begin
      mS2 = mRawD2;
      mCommit = '0;
      for (int b = 0; b < NB; b++) begin
        if (mS2[b] == mF[b]) begin
          mSince[b] = -1;
        end else begin
          if (mSince[b] < 0) mSince[b] = edgeCount;
          if (edgeCount - mSince[b] >= int'(mPeriod)) begin
            mCommit[b] = 1'b1;
            mSince[b] = -1;
          end
        end
      end
      if (mRdPend) begin
        mBusData = modelRead(mRdAddr);
        mValid = 1'b1;
      end else begin
        mValid = 1'b0;
      end
      mIrq = |(mStat & mIen);
      mClr = '0;
      if (mWrPend) begin
        case ({mWrAddr, 2'b00})
          14'h1200: mPeriod = mWrData[7:0];
          14'h1204: mClr[23:0] = mWrData[23:0];
          14'h1208: mClr[33:24] = mWrData[9:0];
          14'h120C: mIen[23:0] = mWrData[23:0];
          14'h1210: mIen[33:24] = mWrData[9:0];
          default: ;
        endcase
      end
      mStat = (mStat & ~mClr) | mCommit;
      mF = mF ^ mCommit;
      mWrPend = write_reg && !mWrPrev;
      mWrPrev = write_reg;
      mWrAddr = busaddress;
      mWrData = busdata_in;
      mRdPend = read_reg && !mRdPrev;
      mRdPrev = read_reg;
      mRdAddr = busaddress;
      mRawD2 = mRawD1;
      mRawD1 = iodatafromgpio;
      edgeCount++;
    end
  end

  always @(negedge CLOCK) begin
    if (checkEn && !reset_reg) begin
      checkOutput("mon_filtered", 64'(iofiltered), 64'(mF));
      checkOutput("mon_irq", 64'(irq), 64'(mIrq));
      checkOutput("mon_valid", 64'(busdata_valid), 64'(mValid));
      checkOutput("mon_busdata", 64'(busdata_out), 64'(mBusData));
    end
  end

  task automatic waitEdge(input int n);
    repeat (n) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic busDrive(input logic [13:0] a, input logic [31:0] d);
    busaddress = a[13:2];
    busdata_in = d;
  endtask

  task automatic busWrite(input logic [13:0] a, input logic [31:0] d);
    busDrive(a, d);
    write_reg = 1'b1;
    waitEdge(1 + int'($urandom_range(0, 2)));
    write_reg = 1'b0;
    waitEdge(2);
  endtask

  task automatic busRead(input string tag, input logic [13:0] a, input logic [31:0] exp);
    busDrive(a, 32'h0);
    read_reg = 1'b1;
    waitEdge(1);
    checkOutput({tag, "_vld_early"}, 64'(busdata_valid), 64'h0);
    waitEdge(1);
    checkOutput({tag, "_vld"}, 64'(busdata_valid), 64'h1);
    checkOutput({tag, "_data"}, 64'(busdata_out), 64'(exp));
    read_reg = 1'b0;
    waitEdge(1);
    checkOutput({tag, "_vld_drop"}, 64'(busdata_valid), 64'h0);
    checkOutput({tag, "_hold"}, 64'(busdata_out), 64'(exp));
    waitEdge(1);
  endtask

  task automatic settle();
    iodatafromgpio = '0;
    waitEdge(12);
    busWrite(14'h1204, 32'h00FF_FFFF);
    busWrite(14'h1208, 32'h0000_03FF);
  endtask

  task automatic applyStimulus();
    logic [63:0] r1, r2, r3;
    logic [13:0] addrs [9];
    logic [13:0] a;
    addrs = '{14'h1200, 14'h1204, 14'h1208, 14'h120C, 14'h1210,
              14'h1214, 14'h1218, 14'h121C, 14'h11FC};
    r1 = {$urandom(), $urandom()};
    r2 = {$urandom(), $urandom()};
    r3 = {$urandom(), $urandom()};
    if ($urandom_range(0, 2) == 0) iodatafromgpio = iodatafromgpio ^ NB'(r1 & r2 & r3);
    a = addrs[$urandom_range(0, 8)];
    busDrive(a, (a == 14'h1200) ? ($urandom() & 32'h7) : $urandom());
    write_reg = ($urandom_range(0, 5) == 0);
    read_reg = ($urandom_range(0, 4) == 0);
    waitEdge(1);
  endtask

  initial begin
    waitEdge(3);
    checkOutput("rst_filtered", 64'(iofiltered), 64'h0);
    checkOutput("rst_irq", 64'(irq), 64'h0);
    checkOutput("rst_valid", 64'(busdata_valid), 64'h0);
    checkOutput("rst_busout", 64'(busdata_out), 64'h0);
    reset_reg = 1'b0;
    checkEn = 1'b1;
    busRead("rst_period", 14'h1200, 32'h4);

    iodatafromgpio[5] = 1'b1;
    waitEdge(6);
    checkOutput("hold5_before", 64'(iofiltered[5]), 64'h0);
    waitEdge(1);
    checkOutput("hold5_at7", 64'(iofiltered[5]), 64'h1);
    busRead("hold5_stat", 14'h1204, 32'h20);
    settle();

    iodatafromgpio[5] = 1'b1;
    waitEdge(4);
    iodatafromgpio[5] = 1'b0;
    waitEdge(12);
    checkOutput("pulse5_filt", 64'(iofiltered), 64'h0);
    busRead("pulse5_stat", 14'h1204, 32'h0);

    busWrite(14'h1210, 32'h1);
    iodatafromgpio[24] = 1'b1;
    waitEdge(7);
    checkOutput("irq24_pre", 64'(irq), 64'h0);
    waitEdge(1);
    checkOutput("irq24_set", 64'(irq), 64'h1);
    busRead("irq24_stat", 14'h1208, 32'h1);
    busDrive(14'h1208, 32'h1);
    write_reg = 1'b1;
    waitEdge(1);
    write_reg = 1'b0;
    checkOutput("irq24_w1c_a", 64'(irq), 64'h1);
    waitEdge(1);
    checkOutput("irq24_w1c_b", 64'(irq), 64'h1);
    waitEdge(1);
    checkOutput("irq24_clear", 64'(irq), 64'h0);
    busWrite(14'h1210, 32'h0);
    settle();

    iodatafromgpio[0] = 1'b1;
    waitEdge(5);
    busDrive(14'h1204, 32'h1);
    write_reg = 1'b1;
    waitEdge(1);
    write_reg = 1'b0;
    waitEdge(1);
    checkOutput("coinc_filt", 64'(iofiltered[0]), 64'h1);
    busRead("coinc_stat", 14'h1204, 32'h1);
    settle();

    busWrite(14'h1200, 32'h0);
    iodatafromgpio[33] = 1'b1;
    waitEdge(2);
    checkOutput("p0_bit33_early", 64'(iofiltered[33]), 64'h0);
    waitEdge(1);
    checkOutput("p0_bit33", 64'(iofiltered[33]), 64'h1);
    busRead("p0_lvl_hi", 14'h1218, 32'h200);
    busRead("p0_lvl_lo", 14'h1214, 32'h0);
    busRead("p0_period", 14'h1200, 32'h0);
    settle();

    busWrite(14'h1200, 32'h2);
    for (int c = 0; c < 3000; c++) applyStimulus();
    write_reg = 1'b0;
    read_reg = 1'b0;
    waitEdge(2);
    busWrite(14'h1200, 32'h4);
    settle();

    iodatafromgpio[7] = 1'b1;
    waitEdge(10);
    checkOutput("prerst_bit7", 64'(iofiltered[7]), 64'h1);
    iodatafromgpio[8] = 1'b1;
    waitEdge(4);
    #2;
    reset_reg = 1'b1;
    #1;
    checkOutput("async_rst_filt", 64'(iofiltered), 64'h0);
    checkOutput("async_rst_irq", 64'(irq), 64'h0);
    waitEdge(2);
    iodatafromgpio = '0;
    reset_reg = 1'b0;
    busRead("postrst_period", 14'h1200, 32'h4);
    checkOutput("postrst_filt", 64'(iofiltered), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
